// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state, error-code and keyboard command definitions
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_NOACK   = 2'b10
  } ps2_err_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte request/response bundle for the PS/2 host transmitter
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic [1:0] tx_err_code;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_done, tx_error, tx_err_code
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_done, tx_error, tx_err_code
  );

endinterface

// File: rtl/ps2_edge_filter.sv
// rtl/ps2_edge_filter.sv - PS/2 clock synchronizer, glitch filter and falling-edge strobe
module ps2_edge_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] run;

  // level only flips after FILTER_LEN consecutive samples disagree with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      level  <= 1'b1;
      run    <= '0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      fall   <= 1'b0;
      if (sync_q[1] == level) begin
        run <= '0;
      end else if (run == CW'(FILTER_LEN - 1)) begin
        level <= sync_q[1];
        run   <= '0;
        fall  <= level;
      end else begin
        run <= run + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 byte transmitter driving open-drain clk/data enables
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES     = 10000,
  parameter int FIRST_EDGE_TIMEOUT = 1500000,
  parameter int BIT_TIMEOUT        = 200000,
  parameter int FILTER_LEN         = 8
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave tx,
  output logic         rx_inhibit,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int MAX_A = (INHIBIT_CYCLES > FIRST_EDGE_TIMEOUT) ? INHIBIT_CYCLES : FIRST_EDGE_TIMEOUT;
  localparam int MAX_T = (MAX_A > BIT_TIMEOUT) ? MAX_A : BIT_TIMEOUT;
  localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_INHIBIT   = INHIBIT;
  localparam logic [2:0] ST_START     = START;
  localparam logic [2:0] ST_SEND      = SEND;
  localparam logic [2:0] ST_ACK       = ACK;
  localparam logic [2:0] ST_WAIT_IDLE = WAIT_IDLE;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [9:0]    frame;
  logic [3:0]    edges;
  logic          data_q;
  logic          done_q;
  logic          error_q;
  logic [1:0]    err_code;
  logic [1:0]    data_sync_q;
  logic          clk_level;
  logic          clk_fall;
  logic          data_sync;
  logic          inhibit_last;
  logic          expired;

  ps2_edge_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .reset (reset),
    .raw   (ps2_clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data_sync_q <= 2'b11;
    else        data_sync_q <= {data_sync_q[0], ps2_data_in};
  end
  assign data_sync = data_sync_q[1];

  assign inhibit_last = (state == ST_INHIBIT) && (cnt == CW'(INHIBIT_CYCLES - 1));
  assign expired      = (state == ST_START) ? (cnt == CW'(FIRST_EDGE_TIMEOUT - 1))
                                            : (cnt == CW'(BIT_TIMEOUT - 1));

  // start bit goes onto the bus during the last inhibit cycle, before the clock is released
  assign ps2_clk_oe     = (state == ST_INHIBIT);
  assign ps2_data_oe    = data_q | inhibit_last;
  assign rx_inhibit     = (state != ST_IDLE);
  assign tx.tx_ready    = (state == ST_IDLE);
  assign tx.tx_done     = done_q;
  assign tx.tx_error    = error_q;
  assign tx.tx_err_code = err_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      frame    <= '0;
      edges    <= '0;
      data_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx.tx_valid) begin
            frame    <= {1'b1, odd_parity(tx.tx_data), tx.tx_data};
            err_code <= ERR_NONE;
            cnt      <= '0;
            state    <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (inhibit_last) begin
            data_q <= 1'b1;
            cnt    <= '0;
            edges  <= '0;
            state  <= ST_START;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_START, ST_SEND: begin
          // frame shifts out D0..D7, parity, stop; an edge beats a coincident timeout
          if (clk_fall) begin
            data_q <= ~frame[0];
            frame  <= {1'b0, frame[9:1]};
            edges  <= edges + 4'd1;
            cnt    <= '0;
            state  <= (edges == 4'd9) ? ST_ACK : ST_SEND;
          end else if (expired) begin
            data_q   <= 1'b0;
            error_q  <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_ACK: begin
          if (clk_fall) begin
            cnt <= '0;
            if (!data_sync) begin
              state <= ST_WAIT_IDLE;
            end else begin
              error_q  <= 1'b1;
              err_code <= ERR_NOACK;
              state    <= ST_IDLE;
            end
          end else if (expired) begin
            error_q  <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WAIT_IDLE: begin
          if (clk_level && data_sync) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end else if (expired) begin
            error_q  <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          data_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
